// File: rtl/wfetch_pkg.sv
// wfetch_pkg: shared types and constants for the weight-fetch AXI read address path.
// Used by wfetch_burst_calc and wfetch_addr_gen.
package wfetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } wfetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         AXI_4K         = 4096;

  function automatic int f_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wfetch_burst_calc.sv
// wfetch_burst_calc: beats in the next burst from address and remaining count.
// Define WFETCH_4K_SPLIT_EN to also stop bursts at 4 KB boundaries.
module wfetch_burst_calc
  import wfetch_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW_BYTES      = 16,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_W         = 16
) (
  input  logic [AW-1:0]    cur_addr,
  input  logic [LEN_W-1:0] remaining,
  output logic [8:0]       len
);

  localparam int          SZ   = f_clog2(DW_BYTES);
  localparam logic [31:0] MAXB = MAX_BURST_LEN;

  logic [31:0] rem32;
  logic        unused_addr;

  assign rem32       = 32'(remaining);
  assign unused_addr = ^cur_addr;

`ifdef WFETCH_4K_SPLIT_EN
  logic [12:0] room;

  // Beats left before the next 4 KB page; at least one for an aligned address.
  assign room = (13'(AXI_4K) - {1'b0, cur_addr[11:0]}) >> SZ;

  always_comb begin
    len = (rem32 > MAXB) ? 9'(MAX_BURST_LEN) : 9'(remaining);
    if (13'(len) > room) len = 9'(room);
  end
`else
  always_comb begin
    len = (rem32 > MAXB) ? 9'(MAX_BURST_LEN) : 9'(remaining);
  end
`endif

endmodule

// File: rtl/wfetch_addr_gen.sv
// wfetch_addr_gen: splits a weight fetch into AXI4 INCR read bursts.
// 4 KB splitting is enabled by defining WFETCH_4K_SPLIT_EN.
module wfetch_addr_gen
  import wfetch_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW_BYTES        = 16,
  parameter int MAX_BURST_LEN   = 16,
  parameter int LEN_W           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_beats,
  output logic [AW-1:0]    araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic             arvalid,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rready,
  input  logic             rlast,
  output logic             busy,
  output logic             done
);

  localparam int SZ = f_clog2(DW_BYTES);
  localparam int OW = f_clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  wfetch_state_e    state;
  logic [AW-1:0]    cur_addr;
  logic [AW-1:0]    nxt_addr;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] nxt_rem;
  logic [8:0]       len_q;
  logic [8:0]       nxt_len;
  logic [7:0]       arlen_q;
  logic             arvalid_q;
  logic             done_q;
  logic [OW-1:0]    outstanding;
  logic [OW-1:0]    out_nxt;
  logic             cmd_hs;
  logic             ar_hs;
  logic             r_done;
  logic             last_burst;

  assign cmd_ready  = (state == ST_IDLE);
  assign cmd_hs     = cmd_valid & cmd_ready;
  assign ar_hs      = arvalid_q & arready;
  assign r_done     = rvalid & rready & rlast;
  assign last_burst = (remaining == LEN_W'(len_q));

  always_comb begin
    out_nxt = outstanding;
    if (ar_hs && !r_done) out_nxt = outstanding + 1'b1;
    if (!ar_hs && r_done) out_nxt = outstanding - 1'b1;
  end

  // Next burst is sized one cycle ahead so AR can go out back-to-back.
  always_comb begin
    nxt_addr = cur_addr;
    nxt_rem  = remaining;
    if (cmd_hs) begin
      nxt_addr = cmd_addr & ~AW'(DW_BYTES - 1);
      nxt_rem  = cmd_beats;
    end else if (ar_hs) begin
      nxt_addr = cur_addr + (AW'(len_q) << SZ);
      nxt_rem  = remaining - LEN_W'(len_q);
    end
  end

  wfetch_burst_calc #(
    .AW           (AW),
    .DW_BYTES     (DW_BYTES),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .LEN_W        (LEN_W)
  ) u_calc (
    .cur_addr (nxt_addr),
    .remaining(nxt_rem),
    .len      (nxt_len)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      len_q       <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      done_q      <= 1'b0;
      outstanding <= '0;
    end else begin
      done_q      <= 1'b0;
      outstanding <= out_nxt;
      if (cmd_hs || ar_hs) begin
        cur_addr  <= nxt_addr;
        remaining <= nxt_rem;
      end
      if ((cmd_hs || ar_hs) && nxt_rem != '0) begin
        len_q   <= nxt_len;
        arlen_q <= 8'(nxt_len - 9'd1);
      end
      unique case (state)
        ST_IDLE: begin
          if (cmd_hs) begin
            if (cmd_beats == '0) begin
              done_q <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              arvalid_q <= (out_nxt < MAX_OUT);
            end
          end
        end
        ST_ISSUE: begin
          if (ar_hs && last_burst) begin
            arvalid_q <= 1'b0;
            state     <= ST_DRAIN;
          end else if (!(arvalid_q && !arready)) begin
            arvalid_q <= (out_nxt < MAX_OUT);
          end
        end
        ST_DRAIN: begin
          if (out_nxt == '0) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(r_done && !ar_hs && outstanding == '0));
  end

  assign araddr  = cur_addr;
  assign arlen   = arlen_q;
  assign arsize  = 3'(SZ);
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;
  assign busy    = (state != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_wfetch_addr_gen.sv
// tb_wfetch_addr_gen: directed vector bench for wfetch_addr_gen.
// Expected bursts follow WFETCH_4K_SPLIT_EN when it is defined.
module tb_wfetch_addr_gen;

  logic        clk;
  logic        rst_n;

  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic        rvalid, rready, rlast;
  logic        busy, done;

  logic        cmd_valid2, cmd_ready2;
  logic [31:0] cmd_addr2;
  logic [15:0] cmd_beats2;
  logic [31:0] araddr2;
  logic [7:0]  arlen2;
  logic [2:0]  arsize2;
  logic [1:0]  arburst2;
  logic        arvalid2, arready2;
  logic        rvalid2, rlast2;
  logic        busy2, done2;

  int pass_cnt = 0;
  int total_cnt = 0;

  wfetch_addr_gen u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_beats(cmd_beats),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arvalid  (arvalid),
    .arready  (arready),
    .rvalid   (rvalid),
    .rready   (rready),
    .rlast    (rlast),
    .busy     (busy),
    .done     (done)
  );

  wfetch_addr_gen #(.MAX_OUTSTANDING(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid2),
    .cmd_ready(cmd_ready2),
    .cmd_addr (cmd_addr2),
    .cmd_beats(cmd_beats2),
    .araddr   (araddr2),
    .arlen    (arlen2),
    .arsize   (arsize2),
    .arburst  (arburst2),
    .arvalid  (arvalid2),
    .arready  (arready2),
    .rvalid   (rvalid2),
    .rready   (rready),
    .rlast    (rlast2),
    .busy     (busy2),
    .done     (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] beats;
    int          n;
    logic [31:0] a [4];
    logic [7:0]  l [4];
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input int beats,
                              input int n,
                              input logic [31:0] a0, input int l0,
                              input logic [31:0] a1, input int l1,
                              input logic [31:0] a2, input int l2);
    vec_t v;
    v.addr  = addr;
    v.beats = 16'(beats);
    v.n     = n;
    v.a[0]  = a0;
    v.l[0]  = 8'(l0);
    v.a[1]  = a1;
    v.l[1]  = 8'(l1);
    v.a[2]  = a2;
    v.l[2]  = 8'(l2);
    v.a[3]  = '0;
    v.l[3]  = '0;
    return v;
  endfunction

  // Runs one command with arready high and one rlast returned per burst.
  task automatic run_vec(input int k, input vec_t v);
    logic [31:0] ga [4];
    logic [7:0]  gl [4];
    int n, pend, dc;
    bit got, prev_r, arf, rf;
    n = 0;
    pend = 0;
    dc = -1;
    got = 0;
    prev_r = 0;
    for (int i = 0; i < 4; i++) begin
      ga[i] = 'x;
      gl[i] = 'x;
    end
    arready = 1'b1;
    rvalid = 1'b0;
    rlast = 1'b0;
    cmd_addr = v.addr;
    cmd_beats = v.beats;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        got = 1;
        dc = c;
        break;
      end
      arf = arvalid && arready;
      rf = rvalid && rlast;
      if (arf && n < 4) begin
        ga[n] = araddr;
        gl[n] = arlen;
      end
      if (arf) n++;
      step();
      if (arf) pend++;
      if (rf) pend--;
      prev_r = rf;
      rvalid = (pend > 0);
      rlast = (pend > 0);
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    chk($sformatf("v%0d_done_seen", k), 32'(got), 1);
    chk($sformatf("v%0d_ar_count", k), n, v.n);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("v%0d_araddr%0d", k, i), ga[i], v.a[i]);
      chk($sformatf("v%0d_arlen%0d", k, i), 32'(gl[i]), 32'(v.l[i]));
    end
    if (v.n == 0) chk($sformatf("v%0d_zero_done_lat", k), dc, 0);
    else chk($sformatf("v%0d_done_after_rlast", k),
             32'(prev_r && pend == 0), 1);
    chk($sformatf("v%0d_cmd_ready", k), 32'(cmd_ready), 1);
    step();
    chk($sformatf("v%0d_done_pulse", k), 32'(done), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int n2, pend2;
    bit got2, arf2, rf2;

    vecs[0] = mk(32'h1000, 40, 3, 32'h1000, 15, 32'h1100, 15, 32'h1200, 7);
`ifdef WFETCH_4K_SPLIT_EN
    vecs[1] = mk(32'h0FC0, 16, 2, 32'h0FC0, 3, 32'h1000, 11, 0, 0);
`else
    vecs[1] = mk(32'h0FC0, 16, 1, 32'h0FC0, 15, 0, 0, 0, 0);
`endif
    vecs[2] = mk(32'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(32'h2008, 5, 1, 32'h2000, 4, 0, 0, 0, 0);
    vecs[4] = mk(32'h3000, 16, 1, 32'h3000, 15, 0, 0, 0, 0);
    vecs[5] = mk(32'h4000, 17, 2, 32'h4000, 15, 32'h4100, 0, 0, 0);
    vecs[6] = mk(32'hFFFFFF00, 32, 2, 32'hFFFFFF00, 15, 32'h0, 15, 0, 0);

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_beats = '0;
    arready = 1'b0;
    rvalid = 1'b0;
    rready = 1'b1;
    rlast = 1'b0;
    cmd_valid2 = 1'b0;
    cmd_addr2 = '0;
    cmd_beats2 = '0;
    arready2 = 1'b0;
    rvalid2 = 1'b0;
    rlast2 = 1'b0;
    step();
    step();
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", 32'(arlen), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("arsize", 32'(arsize), 4);
    chk("arburst", 32'(arburst), 1);

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // AR held off by arready: request must stay frozen.
    arready = 1'b0;
    cmd_addr = 32'h5000;
    cmd_beats = 16'd16;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_arvalid", i), 32'(arvalid), 1);
      chk($sformatf("hold%0d_araddr", i), araddr, 32'h5000);
      chk($sformatf("hold%0d_arlen", i), 32'(arlen), 15);
      step();
    end
    arready = 1'b1;
    step();
    chk("hold_after_hs_arvalid", 32'(arvalid), 0);
    chk("hold_drain_busy", 32'(busy), 1);
    rvalid = 1'b1;
    rlast = 1'b1;
    step();
    rvalid = 1'b0;
    rlast = 1'b0;
    chk("hold_done", 32'(done), 1);
    step();
    chk("hold_done_low", 32'(done), 0);
    chk("hold_idle", 32'(busy), 0);

    // Outstanding limit of 2 with no read data returned.
    arready2 = 1'b1;
    cmd_addr2 = 32'h8000;
    cmd_beats2 = 16'd64;
    cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    n2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (arvalid2 && arready2) n2++;
      step();
    end
    chk("thr_ar_count", n2, 2);
    chk("thr_arvalid_low", 32'(arvalid2), 0);
    rvalid2 = 1'b1;
    rlast2 = 1'b1;
    step();
    rvalid2 = 1'b0;
    rlast2 = 1'b0;
    chk("thr_reissue_valid", 32'(arvalid2), 1);
    chk("thr_reissue_addr", araddr2, 32'h8200);
    chk("thr_reissue_len", 32'(arlen2), 15);
    step();
    chk("thr_full_again", 32'(arvalid2), 0);
    chk("thr_busy", 32'(busy2), 1);

    // Abort with two bursts in flight.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_arvalid", 32'(arvalid2), 0);
    chk("abort_busy", 32'(busy2), 0);
    chk("abort_cmd_ready", 32'(cmd_ready2), 1);

    cmd_addr2 = 32'h9000;
    cmd_beats2 = 16'd32;
    cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    n2 = 0;
    pend2 = 0;
    got2 = 0;
    for (int c = 0; c < 60; c++) begin
      if (done2) begin
        got2 = 1;
        break;
      end
      arf2 = arvalid2 && arready2;
      rf2 = rvalid2 && rlast2;
      if (arf2 && n2 == 0) chk("fresh_addr0", araddr2, 32'h9000);
      if (arf2 && n2 == 1) chk("fresh_addr1", araddr2, 32'h9100);
      if (arf2) n2++;
      step();
      if (arf2) pend2++;
      if (rf2) pend2--;
      rvalid2 = (pend2 > 0);
      rlast2 = (pend2 > 0);
    end
    rvalid2 = 1'b0;
    rlast2 = 1'b0;
    chk("fresh_ar_count", n2, 2);
    chk("fresh_done", 32'(got2), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wfetch_addr_gen.md
# wfetch_addr_gen

Parametrised AXI4 read-address generator for the weight buffer. It accepts a fetch command (start address, total beat count) and splits it into INCR bursts. It holds AR channel signals stable until accepted, limits outstanding bursts and counts R-channel `rlast` to report completion. It replaces the single-step depthwise address stepper and sits between the weight-load controller and the AXI read master port.

## Interface
- `AW`, 32: address width.
- `DW_BYTES`, 16: bytes per data beat, power of two, 1..128.
- `MAX_BURST_LEN`, 16: max beats per burst, 1..256.
- `LEN_W`, 16: width of the command beat count.
- `MAX_OUTSTANDING`, 4: max issued-but-unfinished bursts, ≥1.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset: rst_n, synchronous, active-low; clock clk.
- `cmd_valid`  in  1  fetch command valid.
- `cmd_ready`  out  1  command accepted when both high.
- `cmd_addr`  in  AW  start byte address; low log2(DW_BYTES) bits are forced to 0.
- `cmd_beats`  in  LEN_W  total beats to fetch; 0 is legal.
- `araddr`  out  AW  burst start address.
- `arlen`  out  8  beats-1.
- `arsize`  out  3  constant log2(DW_BYTES).
- `arburst`  out  2  constant 2'b01 (INCR).
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `rvalid`, `rready`, `rlast`  in  1 each  monitored only; this block does not drive `rready`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a command fully completes.

## Operation
- FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE: `cmd_ready`=1. On command handshake, latch `cur_addr` (aligned) and `remaining`=`cmd_beats`.
  - If `cmd_beats`==0: pulse `done` next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE: `cmd_ready`=0.
  - `len` = min(`remaining`, `MAX_BURST_LEN`), clipped by the 4 KB rule when enabled.
  - `arvalid` asserts when `outstanding` < `MAX_OUTSTANDING`.
  - On AR handshake: `cur_addr` += `len`*`DW_BYTES`; `remaining` -= `len`; `outstanding`+1.
  - If that burst consumed all of `remaining`, go to DRAIN.
- DRAIN: wait for `outstanding`==0, then pulse `done` and go to IDLE.
- `outstanding` counter:
  - increments on AR handshake;
  - decrements on `rvalid`&`rready`&`rlast`;
  - both in the same cycle: unchanged.
  - Width is clog2(`MAX_OUTSTANDING`+1). Never exceeds `MAX_OUTSTANDING`; an underflow is an assertion error.
- Address arithmetic wraps modulo 2^AW; no overflow flag.

## Timing
- Reset values: `arvalid`=0, `araddr`=0, `arlen`=0, `busy`=0, `done`=0, `outstanding`=0, state IDLE. `cmd_ready`=1 from the first cycle after reset.
- Command accepted at cycle T → first `arvalid` at T+1, unless throttled.
- AR back-to-back: after a handshake at cycle T, the next burst can present at T+1.
- AXI stability rule: once `arvalid` is high, `araddr`/`arlen`/`arvalid` hold until `arready`. Throttling never drops an already-asserted `arvalid`.
- `done` is asserted one cycle after the final `rlast` handshake.
  - If the final AR and the final `rlast` occur together, that `rlast` belongs to an older burst and DRAIN continues.
- `rst_n` low mid-command aborts everything next edge; AR/R beats in flight are the system's responsibility.

## Configuration
- `WFETCH_4K_SPLIT_EN` defined: `len` is additionally clipped to (4096 − `cur_addr[11:0]`)/`DW_BYTES`, so no burst crosses a 4 KB boundary.
- Not defined: no 4 KB check; bursts are min(`remaining`, `MAX_BURST_LEN`). Callers must guarantee alignment.

## Structure
- Shared package `wfetch_pkg`:
  - state enum `wfetch_state_e`;
  - constants `AXI_BURST_INCR`=2'b01 and `AXI_4K`=4096;
  - function `f_clog2`.
- One combinational sub-module, `wfetch_burst_calc`: inputs `cur_addr`, `remaining`; output `len`. The 4 KB clip lives there under the macro.

## Test plan
- Defaults, `cmd_addr`=0x1000, `cmd_beats`=40, `arready`=1, R returns promptly → ARs (0x1000, len 15), (0x1100, len 15), (0x1200, len 7); `done` one cycle after the third `rlast`.
- `arready` held low 5 cycles on the first burst → `arvalid`/`araddr`/`arlen` constant all 5 cycles; handshake on cycle 6.
- `MAX_OUTSTANDING`=2, `cmd_beats`=64, no R traffic → exactly 2 ARs, then `arvalid` low. One `rlast` → third AR presented the next cycle.
- `cmd_addr`=0x0FC0, `cmd_beats`=16:
  - with the macro: (0x0FC0, len 3), (0x1000, len 11);
  - without it: single (0x0FC0, len 15).
- `cmd_beats`=0 → no `arvalid`; `done` pulses the cycle after accept; `cmd_ready` stays high.
- `rst_n` low for 1 cycle while in ISSUE with `outstanding`=2 → next cycle `arvalid`=0, `busy`=0, `cmd_ready`=1; a fresh command runs normally.
